mem_port_arbiter: RTL and testbench

- Shares one single-port, fixed-latency instruction/data memory between the IF stage (instruction fetch) and the MEM stage (load/store).
- Grants one requester at a time and sequences the multi-cycle access.
- Returns read data and a one-cycle ready pulse to the granted requester.
- Drives the freeze signals that stall IF and the whole pipeline while an access is outstanding.

---
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port fixed-latency memory between IF and MEM.
// Grants one requester at a time. The bus is held for WAIT_CYCLES cycles, then a
// one-cycle ready pulse is issued to the granted requester, followed by one IDLE
// turnaround cycle.
// Optional build macro MEM_ARB_RR_EN: round-robin arbitration instead of fixed
// MEM priority.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_rd_en,
    input  logic              mem_wr_en,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_we,
    output logic              bus_re,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              freez_if,
    output logic              freez_pipe
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              gnt_mem_q, gnt_mem_d;
    logic              flushed_q, flushed_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              mem_pend, if_pend, pick_mem, pick_if;
    logic              in_access, in_done;

    assign mem_pend = mem_rd_en | mem_wr_en;
    assign if_pend  = if_req & ~if_flush;

`ifdef MEM_ARB_RR_EN
    // 0: IF was granted last, 1: MEM was granted last
    logic last_grant_q, last_grant_d;

    // Contested grant goes to whoever did not win last time
    always_comb begin
        pick_mem     = mem_pend & (~if_pend | ~last_grant_q);
        pick_if      = if_pend & ~pick_mem;
        last_grant_d = last_grant_q;
        if (state_q == StIdle && (pick_mem || pick_if)) begin
            last_grant_d = pick_mem;
        end
    end

    // Round-robin history register
    always_ff @(posedge clk) begin
        if (rst) last_grant_q <= 1'b0;
        else     last_grant_q <= last_grant_d;
    end
`else
    // Fixed priority: the older instruction (MEM) always wins
    always_comb begin
        pick_mem = mem_pend;
        pick_if  = if_pend & ~mem_pend;
    end
`endif

    // Next-state: grant, count down the access, capture read data
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        gnt_mem_d   = gnt_mem_q;
        flushed_d   = flushed_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        unique case (state_q)
            StIdle: begin
                if (pick_mem) begin
                    addr_d    = mem_addr;
                    wdata_d   = mem_wdata;
                    we_d      = mem_wr_en;  // rd and wr together counts as a write
                    gnt_mem_d = 1'b1;
                    flushed_d = 1'b0;
                    cnt_d     = 4'(WAIT_CYCLES - 1);
                    state_d   = StAccess;
                end else if (pick_if) begin
                    addr_d    = if_addr;
                    wdata_d   = '0;
                    we_d      = 1'b0;
                    gnt_mem_d = 1'b0;
                    flushed_d = 1'b0;
                    cnt_d     = 4'(WAIT_CYCLES - 1);
                    state_d   = StAccess;
                end
            end
            StAccess: begin
                if (!gnt_mem_q && if_flush) flushed_d = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = StDone;
                    if (!we_q) begin
                        if (gnt_mem_q)                     mem_rdata_d = bus_rdata;
                        else if (!flushed_q && !if_flush)  if_rdata_d  = bus_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs; reset forces every output low in the cycle it is sampled
    always_comb begin
        in_access  = (state_q == StAccess) & ~rst;
        in_done    = (state_q == StDone) & ~rst;
        bus_re     = in_access & ~we_q;
        bus_we     = in_access & we_q;
        bus_addr   = rst ? '0 : addr_q;
        bus_wdata  = rst ? '0 : wdata_q;
        mem_ready  = in_done & gnt_mem_q;
        if_ready   = in_done & ~gnt_mem_q & ~flushed_q & ~if_flush;
        if_rdata   = rst ? '0 : if_rdata_q;
        mem_rdata  = rst ? '0 : mem_rdata_q;
        freez_pipe = ~rst & mem_pend & ~mem_ready;
        freez_if   = ~rst & (freez_pipe | (if_req & ~if_ready & ~if_flush));
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            gnt_mem_q   <= 1'b0;
            flushed_q   <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            gnt_mem_q   <= gnt_mem_d;
            flushed_q   <= flushed_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (default build, fixed MEM priority).
// A transaction-level reference model predicts each cycle from the grant cycle of
// the current access: bus active for grant+1..grant+W, ready at grant+W+1.
module tb_mem_port_arbiter;
    localparam int unsigned W = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, mem_rd_en, mem_wr_en;
    logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
    logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
    logic        if_ready, mem_ready, bus_we, bus_re, freez_if, freez_pipe;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
        .bus_rdata(bus_rdata), .freez_if(freez_if), .freez_pipe(freez_pipe)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model: one outstanding transaction
    bit          busy = 0;
    int          t_start;
    bit          t_mem, t_we, t_fl;
    logic [31:0] t_addr, t_wdata;
    logic [31:0] e_if_rdata = '0, e_mem_rdata = '0;

    // Observation counters
    int n_if_rdy = 0, n_mem_rdy = 0, n_we_cyc = 0, last_mem_cyc = -1, mem_gap = 0;
    bit saw_if_rdy = 0, saw_mem_rdy = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
        end
    endtask

    // Check this cycle's outputs against the model, then advance the model
    task automatic model_cycle();
        logic e_re, e_we, e_ifr, e_memr, e_fp, e_fi;
        bit   act;
        int   k;
        e_re = 0; e_we = 0; e_ifr = 0; e_memr = 0; act = 0; k = 0;
        saw_if_rdy  = if_ready;
        saw_mem_rdy = mem_ready;
        if (bus_we) n_we_cyc++;
        if (if_ready) n_if_rdy++;
        if (mem_ready) begin
            if (last_mem_cyc >= 0) mem_gap = cyc - last_mem_cyc;
            last_mem_cyc = cyc;
            n_mem_rdy++;
        end
        if (rst) begin
            chk("rst_bus_re", {31'b0, bus_re}, 0);
            chk("rst_bus_we", {31'b0, bus_we}, 0);
            chk("rst_if_ready", {31'b0, if_ready}, 0);
            chk("rst_mem_ready", {31'b0, mem_ready}, 0);
            chk("rst_freez_if", {31'b0, freez_if}, 0);
            chk("rst_freez_pipe", {31'b0, freez_pipe}, 0);
            chk("rst_if_rdata", if_rdata, 0);
            chk("rst_mem_rdata", mem_rdata, 0);
            chk("rst_bus_addr", bus_addr, 0);
            busy = 0; e_if_rdata = '0; e_mem_rdata = '0;
            return;
        end
        if (busy) begin
            k = cyc - t_start;
            if (k >= 1 && k <= W) begin
                act = 1; e_re = !t_we; e_we = t_we;
                if (!t_mem && if_flush) t_fl = 1;
            end else if (k == W + 1) begin
                e_memr = t_mem;
                e_ifr  = !t_mem && !t_fl && !if_flush;
            end
        end
        e_fp = (mem_rd_en | mem_wr_en) & ~e_memr;
        e_fi = e_fp | (if_req & ~e_ifr & ~if_flush);
        chk("bus_re", {31'b0, bus_re}, {31'b0, e_re});
        chk("bus_we", {31'b0, bus_we}, {31'b0, e_we});
        chk("if_ready", {31'b0, if_ready}, {31'b0, e_ifr});
        chk("mem_ready", {31'b0, mem_ready}, {31'b0, e_memr});
        chk("freez_pipe", {31'b0, freez_pipe}, {31'b0, e_fp});
        chk("freez_if", {31'b0, freez_if}, {31'b0, e_fi});
        chk("if_rdata", if_rdata, e_if_rdata);
        chk("mem_rdata", mem_rdata, e_mem_rdata);
        if (act) begin
            chk("bus_addr", bus_addr, t_addr);
            if (t_we) chk("bus_wdata", bus_wdata, t_wdata);
        end
        if (busy) begin
            if (k == W && !t_we) begin
                if (t_mem)      e_mem_rdata = bus_rdata;
                else if (!t_fl) e_if_rdata  = bus_rdata;
            end
            if (k == W + 1) busy = 0;
        end else if (mem_rd_en || mem_wr_en) begin
            busy = 1; t_start = cyc; t_mem = 1; t_we = mem_wr_en; t_fl = 0;
            t_addr = mem_addr; t_wdata = mem_wdata;
        end else if (if_req && !if_flush) begin
            busy = 1; t_start = cyc; t_mem = 0; t_we = 0; t_fl = 0;
            t_addr = if_addr; t_wdata = '0;
        end
    endtask

    // One clock cycle: inputs are stable since posedge+1, sample at negedge
    task automatic tick();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        rst = 1; if_req = 0; if_flush = 0; mem_rd_en = 0; mem_wr_en = 0;
        if_addr = '0; mem_addr = '0; mem_wdata = '0; bus_rdata = '0;
        @(posedge clk); #1;
        tick(); tick();
        rst = 0;
        tick();

        // Fetch from 0x10
        if_req = 1; if_addr = 32'h10; bus_rdata = 32'hAABBCCDD;
        repeat (4) tick();
        if_req = 0;
        tick();
        chk("t1_if_rdata", if_rdata, 32'hAABBCCDD);
        chk("t1_if_pulses", n_if_rdy, 1);

        // Store to 0x400
        n_we_cyc = 0;
        mem_wr_en = 1; mem_addr = 32'h400; mem_wdata = 32'h5;
        repeat (4) tick();
        mem_wr_en = 0;
        tick();
        chk("t2_we_cycles", n_we_cyc, 2);
        chk("t2_mem_rdata", mem_rdata, 0);
        chk("t2_mem_pulses", n_mem_rdy, 1);

        // Simultaneous fetch and load: MEM first, IF after turnaround
        if_req = 1; if_addr = 32'h20; mem_rd_en = 1; mem_addr = 32'h300;
        bus_rdata = 32'h11;
        repeat (4) tick();
        mem_rd_en = 0;
        repeat (4) tick();
        if_req = 0;
        tick();
        chk("t3_mem_rdata", mem_rdata, 32'h11);
        chk("t3_if_rdata", if_rdata, 32'h11);
        chk("t3_if_pulses", n_if_rdy, 2);

        // Flush in first ACCESS cycle of a fetch
        if_req = 1; if_addr = 32'h24; bus_rdata = 32'h12345678;
        tick();
        if_flush = 1;
        tick();
        if_flush = 0; if_req = 0;
        repeat (3) tick();
        chk("t4_if_rdata", if_rdata, 32'h11);
        chk("t4_if_pulses", n_if_rdy, 2);

        // Reset in the second ACCESS cycle of a store
        mem_wr_en = 1; mem_addr = 32'h404; mem_wdata = 32'h7;
        tick(); tick();
        rst = 1;
        tick();
        rst = 0; mem_wr_en = 0;
        tick();
        chk("t5_mem_pulses", n_mem_rdy, 2);

        // Back-to-back loads held continuously
        mem_rd_en = 1; mem_addr = 32'h500; bus_rdata = 32'h1;
        repeat (4) tick();
        chk("t6_first_load", mem_rdata, 32'h1);
        bus_rdata = 32'h2;
        repeat (4) tick();
        mem_rd_en = 0;
        tick();
        chk("t6_second_load", mem_rdata, 32'h2);
        chk("t6_gap", mem_gap, 4);
        chk("t6_mem_pulses", n_mem_rdy, 4);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            bus_rdata = $urandom;
            if_addr   = $urandom;
            if_flush  = ($urandom_range(0, 9) == 0);
            rst       = ($urandom_range(0, 99) == 0);
            if (if_req) begin
                if (saw_if_rdy) if_req = $urandom_range(0, 1) == 1;
            end else begin
                if_req = $urandom_range(0, 2) == 0;
            end
            if (mem_rd_en || mem_wr_en) begin
                mem_wdata = $urandom;
                if (saw_mem_rdy && $urandom_range(0, 1) == 1) begin
                    mem_rd_en = 0; mem_wr_en = 0;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 2))
                    0:       begin mem_rd_en = 1; mem_wr_en = 0; end
                    1:       begin mem_rd_en = 0; mem_wr_en = 1; end
                    default: begin mem_rd_en = 1; mem_wr_en = 1; end
                endcase
                mem_addr  = $urandom;
                mem_wdata = $urandom;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
